imem_dmem_arbiter: RTL and testbench

Single-port memory arbiter between the instruction cache's memory-side interface (proc2Imem_*/Imem2proc_*) and the data cache's memory-side interface (proc2Dmem_*/Dmem2proc_*). It forwards at most one request per cycle to main memory and records which requester owns each returned memory tag in a 15-entry owner table. It steers each tagged data return back to that owner. Data requests have priority, bounded by an anti-starvation counter for instruction fetch.

---
 rtl/imem_dmem_arbiter.sv | 109 ++++++++++
 tb/tb_imem_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the I-cache and D-cache memory-side ports onto one memory port.
// Data requests win unless instruction fetch has starved, and tagged returns go back to their owner.
module imem_dmem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  proc2Imem_command,
   input  logic [63:0] proc2Imem_addr,
   input  logic [1:0]  proc2Dmem_command,
   input  logic [63:0] proc2Dmem_addr,
   input  logic [63:0] proc2Dmem_data,
   input  logic [3:0]  mem2proc_response,
   input  logic [63:0] mem2proc_data,
   input  logic [3:0]  mem2proc_tag,
   output logic [1:0]  proc2mem_command,
   output logic [63:0] proc2mem_addr,
   output logic [63:0] proc2mem_data,
   output logic [3:0]  Imem2proc_response,
   output logic [63:0] Imem2proc_data,
   output logic [3:0]  Imem2proc_tag,
   output logic [3:0]  Dmem2proc_response,
   output logic [63:0] Dmem2proc_data,
   output logic [3:0]  Dmem2proc_tag,
   output logic        stray_tag_err
);

   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_LOAD = 2'd1;
   localparam int         CW       = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt;
   logic [15:0]   tag_valid;
   logic [15:0]   tag_owner;   // 0 = instruction side, 1 = data side

   logic i_req, d_req, grant_i, grant_d;
   logic record, ret_hit, ret_stray;

   assign i_req   = (proc2Imem_command != BUS_NONE);
   assign d_req   = (proc2Dmem_command != BUS_NONE);
   assign grant_i = i_req && (!d_req || starve_cnt == LIMIT);
   assign grant_d = d_req && !grant_i;

   // Only loads produce a return, so stores never occupy a table entry.
   assign record = (mem2proc_response != 4'd0) &&
                   ((grant_i && proc2Imem_command == BUS_LOAD) ||
                    (grant_d && proc2Dmem_command == BUS_LOAD));

   assign ret_hit   = (mem2proc_tag != 4'd0) &&  tag_valid[mem2proc_tag];
   assign ret_stray = (mem2proc_tag != 4'd0) && !tag_valid[mem2proc_tag];

   always_comb begin
      proc2mem_command   = BUS_NONE;
      proc2mem_addr      = 64'd0;
      proc2mem_data      = 64'd0;
      Imem2proc_response = 4'd0;
      Dmem2proc_response = 4'd0;
      Imem2proc_tag      = 4'd0;
      Imem2proc_data     = 64'd0;
      Dmem2proc_tag      = 4'd0;
      Dmem2proc_data     = 64'd0;
      if (!reset) begin
         if (grant_d) begin
            proc2mem_command   = proc2Dmem_command;
            proc2mem_addr      = proc2Dmem_addr;
            proc2mem_data      = proc2Dmem_data;
            Dmem2proc_response = mem2proc_response;
         end else if (grant_i) begin
            proc2mem_command   = proc2Imem_command;
            proc2mem_addr      = proc2Imem_addr;
            Imem2proc_response = mem2proc_response;
         end
         if (ret_hit) begin
            if (tag_owner[mem2proc_tag]) begin
               Dmem2proc_tag  = mem2proc_tag;
               Dmem2proc_data = mem2proc_data;
            end else begin
               Imem2proc_tag  = mem2proc_tag;
               Imem2proc_data = mem2proc_data;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt    <= '0;
         tag_valid     <= '0;
         tag_owner     <= '0;
         stray_tag_err <= 1'b0;
      end else begin
         if (i_req && !grant_i)
            starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + CW'(1);
         else
            starve_cnt <= '0;
         if (ret_hit)
            tag_valid[mem2proc_tag] <= 1'b0;
         // Later assignment wins: a tag returned and re-accepted this cycle stays live.
         if (record) begin
            tag_valid[mem2proc_response] <= 1'b1;
            tag_owner[mem2proc_response] <= grant_d;
         end
         if (ret_stray)
            stray_tag_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of grants and tag ownership.
module tb_imem_dmem_arbiter;

   localparam int L = 4;
   localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

   logic        clock, reset;
   logic [1:0]  i_cmd, d_cmd;
   logic [63:0] i_addr, d_addr, d_data;
   logic [3:0]  m_resp, m_tag;
   logic [63:0] m_data;
   logic [1:0]  o_cmd;
   logic [63:0] o_addr, o_data;
   logic [3:0]  i_resp, i_tag, d_resp, d_tag;
   logic [63:0] i_rdata, d_rdata;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state: outstanding tags, who owns them, consecutive I losses
   bit m_valid[16];
   bit m_isd[16];
   int m_losses;
   bit m_err;

   imem_dmem_arbiter #(.STARVE_LIMIT(L)) dut (
      .clock(clock), .reset(reset),
      .proc2Imem_command(i_cmd), .proc2Imem_addr(i_addr),
      .proc2Dmem_command(d_cmd), .proc2Dmem_addr(d_addr), .proc2Dmem_data(d_data),
      .mem2proc_response(m_resp), .mem2proc_data(m_data), .mem2proc_tag(m_tag),
      .proc2mem_command(o_cmd), .proc2mem_addr(o_addr), .proc2mem_data(o_data),
      .Imem2proc_response(i_resp), .Imem2proc_data(i_rdata), .Imem2proc_tag(i_tag),
      .Dmem2proc_response(d_resp), .Dmem2proc_data(d_rdata), .Dmem2proc_tag(d_tag),
      .stray_tag_err(err)
   );

   initial clock = 0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   // 0 = nobody, 1 = instruction side, 2 = data side
   function automatic int model_grant();
      bit ir = (i_cmd != NONE);
      bit dr = (d_cmd != NONE);
      if (ir && dr) return (m_losses >= L) ? 1 : 2;
      if (dr) return 2;
      if (ir) return 1;
      return 0;
   endfunction

   function automatic void model_commit();
      int g;
      if (reset) begin
         foreach (m_valid[k]) m_valid[k] = 0;
         m_losses = 0;
         m_err = 0;
         return;
      end
      g = model_grant();
      if (i_cmd != NONE && g != 1) m_losses = (m_losses + 1 > L) ? L : m_losses + 1;
      else m_losses = 0;
      if (m_tag != 0) begin
         if (m_valid[m_tag]) m_valid[m_tag] = 0;
         else m_err = 1;
      end
      if (m_resp != 0 && ((g == 1 && i_cmd == LOAD) || (g == 2 && d_cmd == LOAD))) begin
         m_valid[m_resp] = 1;
         m_isd[m_resp] = (g == 2);
      end
   endfunction

   task automatic tick();
      model_commit();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      i_cmd = NONE; i_addr = 0; d_cmd = NONE; d_addr = 0; d_data = 0;
      m_resp = 0; m_tag = 0; m_data = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      i_cmd = LOAD; i_addr = 64'h1234; d_cmd = STORE; d_addr = 64'h88; d_data = 64'h99;
      m_resp = 4'd3; m_tag = 4'd3; m_data = 64'hBEEF;
      tick();
      @(negedge clock);
      if (o_cmd !== NONE || o_addr !== 0 || o_data !== 0) begin
         n_fail++; $display("FAIL reset_req: cmd=%0d addr=%h data=%h, expected all 0", o_cmd, o_addr, o_data);
      end
      n_tests++;
      if (i_resp !== 0 || d_resp !== 0 || i_tag !== 0 || d_tag !== 0 || i_rdata !== 0 || d_rdata !== 0) begin
         n_fail++; $display("FAIL reset_ret: iresp=%0d dresp=%0d itag=%0d dtag=%0d, expected all 0", i_resp, d_resp, i_tag, d_tag);
      end
      n_tests++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      n_tests++;
      tick();
      reset = 0; idle();
      tick();
   endtask

   task automatic test_i_load();
      idle(); i_cmd = LOAD; i_addr = 64'h1000; m_resp = 4'd3;
      @(negedge clock);
      if (o_cmd !== LOAD || o_addr !== 64'h1000 || o_data !== 0) begin
         n_fail++; $display("FAIL iload_fwd: cmd=%0d addr=%h data=%h, expected 1/1000/0", o_cmd, o_addr, o_data);
      end
      n_tests++;
      if (i_resp !== 4'd3 || d_resp !== 4'd0) begin
         n_fail++; $display("FAIL iload_resp: i=%0d d=%0d, expected 3/0", i_resp, d_resp);
      end
      n_tests++;
      tick(); idle(); tick();
      m_tag = 4'd3; m_data = 64'hDEAD;
      @(negedge clock);
      if (i_tag !== 4'd3 || i_rdata !== 64'hDEAD || d_tag !== 0 || d_rdata !== 0) begin
         n_fail++; $display("FAIL iload_ret: itag=%0d idata=%h dtag=%0d ddata=%h, expected 3/dead/0/0", i_tag, i_rdata, d_tag, d_rdata);
      end
      n_tests++;
      tick(); idle(); tick();
   endtask

   task automatic test_interleave();
      idle(); i_cmd = LOAD; i_addr = 64'h500; m_resp = 4'd1;
      tick();
      idle(); d_cmd = LOAD; d_addr = 64'h600; m_resp = 4'd2;
      tick();
      idle(); m_tag = 4'd2; m_data = 64'hAAAA;
      @(negedge clock);
      if (d_tag !== 4'd2 || d_rdata !== 64'hAAAA || i_tag !== 0 || i_rdata !== 0) begin
         n_fail++; $display("FAIL ilv_tag2: dtag=%0d ddata=%h itag=%0d, expected 2/aaaa/0", d_tag, d_rdata, i_tag);
      end
      n_tests++;
      tick();
      m_tag = 4'd1; m_data = 64'hBBBB;
      @(negedge clock);
      if (i_tag !== 4'd1 || i_rdata !== 64'hBBBB || d_tag !== 0 || d_rdata !== 0) begin
         n_fail++; $display("FAIL ilv_tag1: itag=%0d idata=%h dtag=%0d, expected 1/bbbb/0", i_tag, i_rdata, d_tag);
      end
      n_tests++;
      tick(); idle(); tick();
   endtask

   task automatic test_starvation();
      logic [63:0] exp_addr [6];
      exp_addr = '{64'h200, 64'h200, 64'h200, 64'h200, 64'h100, 64'h200};
      idle(); i_cmd = LOAD; i_addr = 64'h100; d_cmd = STORE; d_addr = 64'h200; d_data = 64'h7;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (o_addr !== exp_addr[c]) begin
            n_fail++; $display("FAIL starve_c%0d: addr=%h expected %h", c, o_addr, exp_addr[c]);
         end
         n_tests++;
         tick();
      end
      idle(); tick();
   endtask

   task automatic test_simultaneous();
      idle(); i_cmd = LOAD; i_addr = 64'h40; d_cmd = STORE; d_addr = 64'h80; d_data = 64'h55; m_resp = 4'd5;
      @(negedge clock);
      if (o_cmd !== STORE || o_addr !== 64'h80 || o_data !== 64'h55) begin
         n_fail++; $display("FAIL simul_fwd: cmd=%0d addr=%h data=%h, expected 2/80/55", o_cmd, o_addr, o_data);
      end
      n_tests++;
      if (d_resp !== 4'd5 || i_resp !== 4'd0) begin
         n_fail++; $display("FAIL simul_resp: d=%0d i=%0d, expected 5/0", d_resp, i_resp);
      end
      n_tests++;
      tick(); idle(); tick();
      // store must not have claimed tag 5, so its return is stray
      m_tag = 4'd5; m_data = 64'h1;
      @(negedge clock);
      if (i_tag !== 0 || d_tag !== 0) begin
         n_fail++; $display("FAIL simul_notag: itag=%0d dtag=%0d, expected 0/0", i_tag, d_tag);
      end
      n_tests++;
      tick(); idle();
      @(negedge clock);
      if (err !== 1'b1) begin n_fail++; $display("FAIL simul_stray: err=%b expected 1", err); end
      n_tests++;
      tick();
   endtask

   task automatic test_stray();
      idle(); m_tag = 4'd7; m_data = 64'h77;
      @(negedge clock);
      if (i_tag !== 0 || d_tag !== 0 || i_rdata !== 0 || d_rdata !== 0) begin
         n_fail++; $display("FAIL stray_ret: itag=%0d dtag=%0d, expected 0/0", i_tag, d_tag);
      end
      n_tests++;
      tick(); idle();
      for (int c = 0; c < 3; c++) tick();
      @(negedge clock);
      if (err !== 1'b1) begin n_fail++; $display("FAIL stray_hold: err=%b expected 1", err); end
      n_tests++;
      tick();
   endtask

   task automatic test_reset_mid();
      reset = 1; idle(); tick(); reset = 0; tick();
      @(negedge clock);
      if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_clear: err=%b expected 0", err); end
      n_tests++;
      idle(); d_cmd = LOAD; d_addr = 64'h900; m_resp = 4'd4;
      tick();
      reset = 1; idle(); d_cmd = LOAD; d_addr = 64'h910; m_resp = 4'd6; m_tag = 4'd4; m_data = 64'h44;
      @(negedge clock);
      if (o_cmd !== NONE || d_resp !== 0 || d_tag !== 0 || d_rdata !== 0) begin
         n_fail++; $display("FAIL rmid_force: cmd=%0d dresp=%0d dtag=%0d, expected 0/0/0", o_cmd, d_resp, d_tag);
      end
      n_tests++;
      tick();
      reset = 0; idle(); m_tag = 4'd4; m_data = 64'h44;
      @(negedge clock);
      if (d_tag !== 0 || d_rdata !== 0 || i_tag !== 0) begin
         n_fail++; $display("FAIL rmid_drop: dtag=%0d ddata=%h, expected 0/0", d_tag, d_rdata);
      end
      n_tests++;
      tick(); idle();
      @(negedge clock);
      if (err !== 1'b1) begin n_fail++; $display("FAIL rmid_err: err=%b expected 1", err); end
      n_tests++;
      tick();
   endtask

   task automatic test_random();
      int g, t;
      logic [1:0]  e_cmd;
      logic [63:0] e_addr, e_data, e_idata, e_ddata;
      logic [3:0]  e_iresp, e_dresp, e_itag, e_dtag;
      reset = 1; idle(); tick(); reset = 0; tick();
      for (int c = 0; c < 400; c++) begin
         i_cmd  = ($urandom_range(0, 2) != 0) ? LOAD : NONE;
         i_addr = {$urandom, $urandom};
         d_cmd  = 2'($urandom_range(0, 2));
         d_addr = {$urandom, $urandom};
         d_data = {$urandom, $urandom};
         t = $urandom_range(1, 15);
         m_resp = (m_valid[t] || $urandom_range(0, 4) == 0) ? 4'd0 : 4'(t);
         t = $urandom_range(1, 15);
         m_tag  = (m_valid[t] && $urandom_range(0, 1) == 1) ? 4'(t) : 4'd0;
         m_data = {$urandom, $urandom};
         g = model_grant();
         e_cmd   = (g == 1) ? i_cmd  : (g == 2) ? d_cmd  : NONE;
         e_addr  = (g == 1) ? i_addr : (g == 2) ? d_addr : 64'd0;
         e_data  = (g == 2) ? d_data : 64'd0;
         e_iresp = (g == 1) ? m_resp : 4'd0;
         e_dresp = (g == 2) ? m_resp : 4'd0;
         e_itag = 0; e_dtag = 0; e_idata = 0; e_ddata = 0;
         if (m_tag != 0 && m_valid[m_tag]) begin
            if (m_isd[m_tag]) begin e_dtag = m_tag; e_ddata = m_data; end
            else begin e_itag = m_tag; e_idata = m_data; end
         end
         @(negedge clock);
         if (o_cmd !== e_cmd || o_addr !== e_addr || o_data !== e_data) begin
            n_fail++; $display("FAIL rnd_fwd c%0d: cmd=%0d addr=%h data=%h, expected %0d/%h/%h", c, o_cmd, o_addr, o_data, e_cmd, e_addr, e_data);
         end
         n_tests++;
         if (i_resp !== e_iresp || d_resp !== e_dresp) begin
            n_fail++; $display("FAIL rnd_resp c%0d: i=%0d d=%0d, expected %0d/%0d", c, i_resp, d_resp, e_iresp, e_dresp);
         end
         n_tests++;
         if (i_tag !== e_itag || d_tag !== e_dtag || i_rdata !== e_idata || d_rdata !== e_ddata) begin
            n_fail++; $display("FAIL rnd_ret c%0d: itag=%0d dtag=%0d, expected %0d/%0d", c, i_tag, d_tag, e_itag, e_dtag);
         end
         n_tests++;
         if (err !== m_err) begin
            n_fail++; $display("FAIL rnd_err c%0d: err=%b expected %b", c, err, m_err);
         end
         n_tests++;
         tick();
      end
      idle(); tick();
   endtask

   initial begin
      foreach (m_valid[k]) begin m_valid[k] = 0; m_isd[k] = 0; end
      m_losses = 0; m_err = 0;
      reset = 1; idle();
      @(posedge clock); #1;
      test_reset();
      test_i_load();
      test_interleave();
      test_starvation();
      test_simultaneous();
      test_stray();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
